// File: rtl/multicycle_decode.sv
// Multi-cycle decode/execute FSM for the FakeCPU core: one instruction per run/ok handshake.
// Optional beq/bne support is built when MULTICYCLE_DECODE_BRANCH_EN is defined.
module multicycle_decode #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int MEM_AW     = 17,
  parameter int PC_W       = 19,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [31:0]       instr,
  input  logic [PC_W-1:0]   pc,
  output logic              ok,
  output logic              illegal,
  output logic              ovf,
  output logic [REG_AW-1:0] reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [REG_AW-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wren,
  output logic [MEM_AW-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [MEM_AW-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic [PC_W-1:0]   pc_wdata,
  output logic              pc_wren
);

  localparam int MSB = DATA_W - 1;
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
`ifdef MULTICYCLE_DECODE_BRANCH_EN
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  typedef enum logic [2:0] {IDLE, DECODE, RD_RS, RD_RT, EXEC, MEM_WAIT, WB, DONE} state_t;

  state_t            state;
  logic [5:0]        ir_op;
  logic [5:0]        ir_fn;
  logic [REG_AW-1:0] ir_rt;
  logic [REG_AW-1:0] ir_rd;
  logic [25:0]       ir_imm26;
  logic [DATA_W-1:0] rs_val;
  logic [2:0]        cnt;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_R: is_legal = (fn <= 6'h07) || (fn == 6'h0a) || (fn == 6'h0b);
      OP_J, OP_BLEZ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW: is_legal = 1'b1;
`ifdef MULTICYCLE_DECODE_BRANCH_EN
      OP_BEQ, OP_BNE: is_legal = 1'b1;
`endif
      default: is_legal = 1'b0;
    endcase
  endfunction

  logic signed [15:0] imm16;
  logic [DATA_W-1:0]  imm_sx, imm_zx, opa, opb, sum, diff, alu_res;
  logic [5:0]         alu_fn;
  logic               short_path, rt_read, alu_ovf, blez_taken;
  logic [REG_AW-1:0]  dest;
  logic [MEM_AW-1:0]  ea;
  logic [PC_W-1:0]    br_target, j_target;
`ifdef MULTICYCLE_DECODE_BRANCH_EN
  logic               beq_taken;
`endif

  // Operand selection and ALU. Short-path ops see rs data directly on reg_rdata in EXEC.
  always_comb begin
    imm16      = ir_imm26[25:10];
    imm_sx     = DATA_W'(imm16);
    imm_zx     = DATA_W'(ir_imm26[25:10]);
    short_path = (ir_op == OP_LW) || (ir_op == OP_BLEZ) || (ir_op == OP_J);
    rt_read    = (ir_op == OP_R) || (ir_op == OP_SW);
`ifdef MULTICYCLE_DECODE_BRANCH_EN
    rt_read    = rt_read || (ir_op == OP_BEQ) || (ir_op == OP_BNE);
`endif
    opa = short_path ? reg_rdata : rs_val;
    case (ir_op)
      OP_ADDI:  begin opb = imm_sx; alu_fn = 6'h00; end
      OP_ADDIU: begin opb = imm_sx; alu_fn = 6'h01; end
      OP_SLTI:  begin opb = imm_sx; alu_fn = 6'h0a; end
      OP_SLTIU: begin opb = imm_sx; alu_fn = 6'h0b; end
      OP_ANDI:  begin opb = imm_zx; alu_fn = 6'h04; end
      OP_ORI:   begin opb = imm_zx; alu_fn = 6'h05; end
      OP_XORI:  begin opb = imm_zx; alu_fn = 6'h06; end
      default:  begin opb = reg_rdata; alu_fn = ir_fn; end
    endcase
    sum     = opa + opb;
    diff    = opa - opb;
    alu_ovf = 1'b0;
    case (alu_fn)
      6'h00: begin
        alu_res = sum;
        alu_ovf = (opa[MSB] == opb[MSB]) && (sum[MSB] != opa[MSB]);
      end
      6'h01: alu_res = sum;
      6'h02: begin
        alu_res = diff;
        alu_ovf = (opa[MSB] != opb[MSB]) && (diff[MSB] != opa[MSB]);
      end
      6'h03: alu_res = diff;
      6'h04: alu_res = opa & opb;
      6'h05: alu_res = opa | opb;
      6'h06: alu_res = opa ^ opb;
      6'h07: alu_res = ~(opa | opb);
      6'h0a: alu_res = DATA_W'($signed(opa) < $signed(opb));
      6'h0b: alu_res = DATA_W'(opa < opb);
      default: alu_res = '0;
    endcase
    dest       = (ir_op == OP_R) ? ir_rd : ir_rt;
    ea         = MEM_AW'(opa + imm_sx);
    br_target  = pc + PC_W'(32'd4) + (PC_W'(imm16) << 2);
    j_target   = PC_W'({ir_imm26, 2'b00});
    blez_taken = opa[MSB] || (opa == '0);
`ifdef MULTICYCLE_DECODE_BRANCH_EN
    beq_taken  = (ir_op == OP_BEQ) ? (opa == reg_rdata) : (opa != reg_rdata);
`endif
  end

  // Control FSM; all outputs registered, write strobes self-clear every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ok        <= 1'b0;
      illegal   <= 1'b0;
      ovf       <= 1'b0;
      reg_raddr <= '0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      reg_wren  <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
      pc_wdata  <= '0;
      pc_wren   <= 1'b0;
      ir_op     <= '0;
      ir_fn     <= '0;
      ir_rt     <= '0;
      ir_rd     <= '0;
      ir_imm26  <= '0;
      rs_val    <= '0;
      cnt       <= '0;
    end else begin
      reg_wren <= 1'b0;
      mem_wren <= 1'b0;
      pc_wren  <= 1'b0;
      if (state != IDLE && !run) begin
        state   <= IDLE;
        ok      <= 1'b0;
        illegal <= 1'b0;
        ovf     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            ok      <= 1'b0;
            illegal <= 1'b0;
            ovf     <= 1'b0;
            state   <= (run && !ok) ? DECODE : IDLE;
          end
          DECODE: begin
            ir_op    <= instr[5:0];
            ir_fn    <= instr[31:26];
            ir_rt    <= REG_AW'(instr[15:11]);
            ir_rd    <= REG_AW'(instr[20:16]);
            ir_imm26 <= instr[31:6];
            if (is_legal(instr[5:0], instr[31:26])) begin
              reg_raddr <= REG_AW'(instr[10:6]);
              state     <= RD_RS;
            end else begin
              illegal <= 1'b1;
              ok      <= 1'b1;
              state   <= DONE;
            end
          end
          RD_RS: begin
            if (rt_read) reg_raddr <= ir_rt;
            state <= short_path ? EXEC : RD_RT;
          end
          RD_RT: begin
            rs_val <= reg_rdata;
            state  <= EXEC;
          end
          EXEC: begin
            case (ir_op)
              OP_LW: begin
                mem_raddr <= ea;
                cnt       <= 3'(MEM_RD_LAT);
                state     <= MEM_WAIT;
              end
              OP_SW: begin
                mem_waddr <= ea;
                mem_wdata <= reg_rdata;
                mem_wren  <= 1'b1;
                ok        <= 1'b1;
                state     <= DONE;
              end
              OP_BLEZ: begin
                pc_wdata <= br_target;
                pc_wren  <= blez_taken;
                ok       <= 1'b1;
                state    <= DONE;
              end
              OP_J: begin
                pc_wdata <= j_target;
                pc_wren  <= 1'b1;
                ok       <= 1'b1;
                state    <= DONE;
              end
`ifdef MULTICYCLE_DECODE_BRANCH_EN
              OP_BEQ, OP_BNE: begin
                pc_wdata <= br_target;
                pc_wren  <= beq_taken;
                ok       <= 1'b1;
                state    <= DONE;
              end
`endif
              default: begin
                reg_waddr <= dest;
                reg_wdata <= alu_res;
                ovf       <= alu_ovf;
                reg_wren  <= !alu_ovf && (dest != '0);
                state     <= WB;
              end
            endcase
          end
          MEM_WAIT: begin
            if (cnt == 3'd0) begin
              reg_waddr <= dest;
              reg_wdata <= mem_rdata;
              reg_wren  <= (dest != '0);
              state     <= WB;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
          WB: begin
            ok    <= 1'b1;
            state <= DONE;
          end
          DONE: state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
